vx_mp_ram: RTL and testbench
============================

// Module: vx_mp_ram
// PURPOSE
//  Multi-read-port, single-write-port RAM. Next generation of the core's dual-port RAM.
//  Adds parametrised lane width for write enables, N read ports and per-port read enables.
//  Adds per-lane write-first/read-first bypass and a hardware clear sequencer after reset.
//  Used by cache tag/data arrays and register files that need post-reset clearing
//  without $readmemh.
// PARAMETERS
//  DATAW       32    word width in bits
//  SIZE        64    number of words (>=2)
//  WRENW       1     write-enable lanes; DATAW % WRENW == 0; lane width LW = DATAW/WRENW
//  NUM_RPORTS  2     read ports (>=1)
//  OUT_REG     0     0: combinational read; 1: registered read, 1-cycle latency
//  RW_BYPASS   1     1: write-first (same-cycle write visible to read); 0: read-first
//  INIT_VALUE  0     [DATAW-1:0] value written to every entry by the clear sequence
//  ADDRW       $clog2(SIZE)  address width (derived)
// PORTS
//  clk         in   1                  clock
//  reset_n     in   1                  synchronous, active-low reset
//  init_busy   out  1                  clear sequence in progress; RAM not usable
//  wren        in   WRENW              per-lane write enable
//  waddr       in   ADDRW              write address
//  wdata       in   DATAW              write data; lane i = wdata[i*LW +: LW]
//  ren         in   NUM_RPORTS         per-port read enable (used only when OUT_REG=1)
//  raddr       in   NUM_RPORTS*ADDRW   read addresses; port p = raddr[p*ADDRW +: ADDRW]
//  rdata       out  NUM_RPORTS*DATAW   read data; port p = rdata[p*DATAW +: DATAW]
//  rvalid      out  NUM_RPORTS         rdata[p] holds a fresh read result
// BEHAVIOUR
//  Reset
//   - Sampled at posedge only.
//   - While reset_n=0: state=RESET, init_busy=1, rvalid=0, OUT_REG rdata regs=INIT_VALUE.
//  Clear FSM (RESET -> CLEAR -> READY)
//   - RESET -> CLEAR on the first edge with reset_n=1; counter cnt=0.
//   - In CLEAR, each cycle writes INIT_VALUE to ram[cnt] (all lanes), then cnt++.
//   - CLEAR -> READY after cnt==SIZE-1 is written.
//   - init_busy deasserts exactly SIZE cycles after reset release.
//   - reset_n=0 at any point, including mid-CLEAR, returns to RESET; clear restarts at 0.
//  While init_busy=1
//   - wren and ren are ignored (writes dropped, no reads issued).
//   - rvalid=0; combinational rdata is don't-care.
//  Write (READY)
//   - ram[waddr] lane i <= wdata lane i when wren[i]=1; other lanes keep their value.
//  Read, OUT_REG=0
//   - rdata[p] = ram[raddr[p]] combinationally.
//   - If RW_BYPASS=1 and wren[i] && waddr==raddr[p]: lane i shows wdata lane i.
//   - rvalid[p] = !init_busy.
//  Read, OUT_REG=1
//   - ren[p] at edge N: rdata[p] is updated at N+1 and rvalid[p]=1 for that cycle.
//   - ren[p]=0: rdata[p] holds its last value and rvalid[p]=0.
//   - Same-edge write to raddr[p]: RW_BYPASS=1 returns new lane data (masked by wren).
//     RW_BYPASS=0 returns pre-write data.
//  Multiple read ports
//   - All ports may hit the same address simultaneously with identical results.
//   - Read ports never conflict.
// STRUCTURE
//  - Shared package vx_ram_pkg: typedef enum logic [1:0] {RAM_RESET, RAM_CLEAR, RAM_READY}.
//  - vx_ram_pkg also holds a lane-merge function:
//      merge(old, new, wren) -> word with enabled lanes replaced.
//  - Sub-module vx_ram_clear_ctrl holds FSM + counter. Ports: clk, reset_n, busy,
//    clr_en, clr_addr.
//  - Top muxes the clear write into the write port; one always block per read port.
//  - Parameter checks via `STATIC_ASSERT: DATAW%WRENW, SIZE>=2, NUM_RPORTS>=1.
// TESTING
//  1. Release reset, SIZE=64
//     -> init_busy=1 for exactly 64 cycles, then 0.
//     -> Reading all 64 addresses on port 0 returns INIT_VALUE (e.g. 32'hDEADBEEF).
//  2. Reset pulse at CLEAR cnt=20 (entries previously 32'h1)
//     -> clear restarts at 0; busy lasts a full 64 cycles after second release.
//     -> All entries read INIT_VALUE.
//  3. WRENW=4, ram[5]=32'h11223344, write wdata=32'hAABBCCDD with wren=4'b0101
//     -> ram[5] reads 32'h11BB33DD.
//  4. OUT_REG=1, same-edge write 32'h55 and read on ports 0 and 1 to addr 9
//     (old value 32'h7), RW_BYPASS=1 -> both ports return 32'h55 with rvalid=1.
//     -> Repeat with RW_BYPASS=0 -> both return 32'h7.
//  5. OUT_REG=1, ren[1]=0 for 3 cycles after a read of 32'hA
//     -> rdata port 1 stays 32'hA, rvalid[1]=0.
//  6. Write and read attempted during init_busy
//     -> after READY, the target address still holds INIT_VALUE; rvalid stays 0 while busy.

Source files
------------

// File: rtl/vx_ram_pkg.sv
// Shared RAM definitions: clear-sequencer states, the lane-merge helper used for
// write-first forwarding, and a compile-time parameter check macro.
`ifndef STATIC_ASSERT
`define STATIC_ASSERT(label, cond, msg) \
  if (!(cond)) begin : label \
    $error(msg); \
  end
`endif

package vx_ram_pkg;

  typedef enum logic [1:0] {
    RAM_RESET = 2'd0,
    RAM_CLEAR = 2'd1,
    RAM_READY = 2'd2
  } ram_state_e;

  // Widest word the merge helper handles; one enable bit per data bit at most.
  localparam int RAM_MAX_DATAW = 512;

  // Replace the lanes of old_word selected by wren with the same lanes of new_word.
  // lane_w is the lane width in bits; it is a constant at every call site.
  function automatic logic [RAM_MAX_DATAW-1:0] merge(
    input logic [RAM_MAX_DATAW-1:0] old_word,
    input logic [RAM_MAX_DATAW-1:0] new_word,
    input logic [RAM_MAX_DATAW-1:0] wren,
    input int                       lane_w
  );
    logic [RAM_MAX_DATAW-1:0] res;
    res = old_word;
    for (int b = 0; b < RAM_MAX_DATAW; b++) begin
      if (wren[b / lane_w]) res[b] = new_word[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/vx_ram_clear_ctrl.sv
// Post-reset clear sequencer: walks every address once, emitting a write strobe
// and address, and holds busy until the last entry has been written.
module vx_ram_clear_ctrl
  import vx_ram_pkg::*;
#(
  parameter int SIZE  = 64,
  parameter int ADDRW = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             busy,
  output logic             clr_en,
  output logic [ADDRW-1:0] clr_addr
);

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(SIZE - 1);

  ram_state_e       state_q, state_d;
  logic [ADDRW-1:0] cnt_q, cnt_d;

  // State and counter registers; reset always restarts the clear from address 0
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RAM_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: one entry cleared per cycle, leave CLEAR after the last one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RAM_RESET: begin
        state_d = RAM_CLEAR;
        cnt_d   = '0;
      end
      RAM_CLEAR: begin
        cnt_d = cnt_q + ADDRW'(1);
        if (cnt_q == LAST_ADDR) state_d = RAM_READY;
      end
      RAM_READY: state_d = RAM_READY;
      default:   state_d = RAM_RESET;
    endcase
  end

  // Outputs decoded from the current state only
  always_comb begin
    busy     = (state_q != RAM_READY);
    clr_en   = (state_q == RAM_CLEAR);
    clr_addr = cnt_q;
  end

endmodule

// File: rtl/vx_mp_ram.sv
// Multi-read-port, single-write-port RAM with per-lane write enables, optional
// registered reads, write-first/read-first selection and a hardware clear after reset.
module vx_mp_ram
  import vx_ram_pkg::*;
#(
  parameter int               DATAW      = 32,
  parameter int               SIZE       = 64,
  parameter int               WRENW      = 1,
  parameter int               NUM_RPORTS = 2,
  parameter int               OUT_REG    = 0,
  parameter int               RW_BYPASS  = 1,
  parameter logic [DATAW-1:0] INIT_VALUE = '0,
  parameter int               ADDRW      = $clog2(SIZE)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  output logic                        init_busy,
  input  logic [WRENW-1:0]            wren,
  input  logic [ADDRW-1:0]            waddr,
  input  logic [DATAW-1:0]            wdata,
  input  logic [NUM_RPORTS-1:0]       ren,
  input  logic [NUM_RPORTS*ADDRW-1:0] raddr,
  output logic [NUM_RPORTS*DATAW-1:0] rdata,
  output logic [NUM_RPORTS-1:0]       rvalid
);

  localparam int LW = DATAW / WRENW;

  `STATIC_ASSERT(chk_lanes, (DATAW % WRENW) == 0, "DATAW must be a multiple of WRENW")
  `STATIC_ASSERT(chk_size, SIZE >= 2, "SIZE must be at least 2")
  `STATIC_ASSERT(chk_ports, NUM_RPORTS >= 1, "NUM_RPORTS must be at least 1")
  `STATIC_ASSERT(chk_width, DATAW <= RAM_MAX_DATAW, "DATAW exceeds merge helper width")

  logic             clr_en;
  logic [ADDRW-1:0] clr_addr;

  vx_ram_clear_ctrl #(
    .SIZE  (SIZE),
    .ADDRW (ADDRW)
  ) u_clear (
    .clk      (clk),
    .reset_n  (reset_n),
    .busy     (init_busy),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  // User writes are dropped entirely while the clear sequence owns the RAM.
  logic [WRENW-1:0] user_wren;
  assign user_wren = init_busy ? '0 : wren;

  logic [WRENW-1:0] mem_wren;
  logic [ADDRW-1:0] mem_waddr;
  logic [DATAW-1:0] mem_wdata;

  // Write-port mux: clear sequencer writes all lanes, otherwise the user port
  always_comb begin
    mem_wren  = user_wren;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (clr_en) begin
      mem_wren  = '1;
      mem_waddr = clr_addr;
      mem_wdata = INIT_VALUE;
    end
  end

  logic [DATAW-1:0] mem_q [SIZE];

  // Storage write with independent lane enables
  always_ff @(posedge clk) begin
    for (int i = 0; i < WRENW; i++) begin
      if (mem_wren[i]) mem_q[mem_waddr][i*LW +: LW] <= mem_wdata[i*LW +: LW];
    end
  end

  for (genvar gi = 0; gi < NUM_RPORTS; gi++) begin : g_rport
    logic [ADDRW-1:0] ra;
    logic [DATAW-1:0] fwd_word;

    assign ra = raddr[gi*ADDRW +: ADDRW];
    // Write-first: lanes being written to this address this cycle show the new data.
    assign fwd_word = (RW_BYPASS != 0 && waddr == ra)
                    ? DATAW'(merge(RAM_MAX_DATAW'(mem_q[ra]), RAM_MAX_DATAW'(wdata),
                                   RAM_MAX_DATAW'(user_wren), LW))
                    : mem_q[ra];

    if (OUT_REG != 0) begin : g_reg
      logic [DATAW-1:0] rdata_q;
      logic             rvalid_q;

      // Registered read: capture on enable, otherwise hold data and drop valid
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          rdata_q  <= INIT_VALUE;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= ren[gi] && !init_busy;
          if (ren[gi] && !init_busy) rdata_q <= fwd_word;
        end
      end

      assign rdata[gi*DATAW +: DATAW] = rdata_q;
      assign rvalid[gi]               = rvalid_q;
    end else begin : g_comb
      logic [DATAW-1:0] rdata_d;
      logic             unused_ren;

      // Combinational read straight from the array (plus forwarding)
      always_comb begin
        rdata_d = fwd_word;
      end

      assign unused_ren               = ren[gi];
      assign rdata[gi*DATAW +: DATAW] = rdata_d;
      assign rvalid[gi]               = !init_busy;
    end
  end

endmodule

// File: tb/tb_vx_mp_ram.sv
// Directed bench for vx_mp_ram: three instances share stimulus
//   dut_a: combinational read, write-first
//   dut_b: registered read, write-first
//   dut_c: registered read, read-first
module tb_vx_mp_ram;

  localparam int          DATAW = 32;
  localparam int          SIZE  = 64;
  localparam int          ADDRW = 6;
  localparam logic [31:0] INIT  = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  wren;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic [1:0]  ren;
  logic [11:0] raddr;

  logic        busy_a, busy_b, busy_c;
  logic [63:0] rdata_a, rdata_b, rdata_c;
  logic [1:0]  rvalid_a, rvalid_b, rvalid_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vx_mp_ram #(.DATAW(DATAW), .SIZE(SIZE), .WRENW(4), .NUM_RPORTS(2), .OUT_REG(0),
              .RW_BYPASS(1), .INIT_VALUE(INIT)) dut_a (
    .clk(clk), .reset_n(reset_n), .init_busy(busy_a), .wren(wren), .waddr(waddr),
    .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a));

  vx_mp_ram #(.DATAW(DATAW), .SIZE(SIZE), .WRENW(4), .NUM_RPORTS(2), .OUT_REG(1),
              .RW_BYPASS(1), .INIT_VALUE(INIT)) dut_b (
    .clk(clk), .reset_n(reset_n), .init_busy(busy_b), .wren(wren), .waddr(waddr),
    .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b));

  vx_mp_ram #(.DATAW(DATAW), .SIZE(SIZE), .WRENW(4), .NUM_RPORTS(2), .OUT_REG(1),
              .RW_BYPASS(0), .INIT_VALUE(INIT)) dut_c (
    .clk(clk), .reset_n(reset_n), .init_busy(busy_c), .wren(wren), .waddr(waddr),
    .wdata(wdata), .ren(ren), .raddr(raddr), .rdata(rdata_c), .rvalid(rvalid_c));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    $display("chk %0d %s obs=%h exp=%h", total, tag, obs, exp);
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count busy cycles after release; drives a dropped write/read attempt meanwhile.
  task automatic count_busy(output int cycles, output logic rv_seen);
    cycles  = 0;
    rv_seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (!busy_a) break;
      cycles++;
      rv_seen = rv_seen | (|rvalid_a) | (|rvalid_b) | (|rvalid_c);
    end
  endtask

  initial begin
    int   cyc;
    logic rv;

    reset_n = 1'b0;
    wren    = '0;
    waddr   = '0;
    wdata   = '0;
    ren     = '0;
    raddr   = '0;

    // Reset state
    repeat (3) tick();
    check("rst_busy", {busy_a, busy_b, busy_c}, 3'b111);
    check("rst_rvalid", {rvalid_a, rvalid_b, rvalid_c}, 6'b0);
    check("rst_rdata_b", rdata_b, {INIT, INIT});
    check("rst_rdata_c", rdata_c, {INIT, INIT});

    // 1. Release: busy for exactly SIZE cycles, then every entry reads INIT
    reset_n = 1'b1;
    count_busy(cyc, rv);
    check("clr1_busy_cycles", 64'(cyc), 64'd64);
    check("clr1_rvalid_while_busy", 64'(rv), 64'd0);
    check("clr1_busy_bc", {busy_b, busy_c}, 2'b00);
    check("clr1_rvalid_a", 64'(rvalid_a), 64'b11);
    for (int a = 0; a < SIZE; a++) begin
      raddr[5:0] = 6'(a);
      #1;
      check($sformatf("clr1_rd[%0d]", a), 64'(rdata_a[31:0]), 64'(INIT));
    end

    // 2. Fill with 1, then interrupt the clear at cnt=20 and restart
    for (int a = 0; a < SIZE; a++) begin
      waddr = 6'(a);
      wdata = 32'h1;
      wren  = 4'hF;
      tick();
    end
    wren = '0;
    raddr[5:0] = 6'd40;
    #1;
    check("fill_rd40", 64'(rdata_a[31:0]), 64'h1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (21) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    // 6. Write and read attempted throughout the busy window
    wren  = 4'hF;
    waddr = 6'd3;
    wdata = 32'h12345678;
    ren   = 2'b11;
    raddr = {6'd3, 6'd3};
    count_busy(cyc, rv);
    wren = '0;
    ren  = '0;
    check("clr2_busy_cycles", 64'(cyc), 64'd64);
    check("busy_rvalid_b_c", 64'(rv), 64'd0);
    for (int a = 0; a < SIZE; a++) begin
      raddr[11:6] = 6'(a);
      #1;
      check($sformatf("clr2_rd[%0d]", a), 64'(rdata_a[63:32]), 64'(INIT));
    end
    raddr[5:0] = 6'd3;
    #1;
    check("busy_write_dropped", 64'(rdata_a[31:0]), 64'(INIT));

    // 3. Lane-masked write
    waddr = 6'd5; wdata = 32'h11223344; wren = 4'hF;
    tick();
    wdata = 32'hAABBCCDD; wren = 4'b0101;
    tick();
    wren = '0;
    raddr[5:0] = 6'd5;
    #1;
    check("lane_merge_a", 64'(rdata_a[31:0]), 64'h11BB33DD);
    ren = 2'b01;
    tick();
    ren = '0;
    check("lane_merge_b", 64'(rdata_b[31:0]), 64'h11BB33DD);
    check("lane_merge_rvalid_b", 64'(rvalid_b), 64'b01);
    // Combinational write-first forwarding, masked to lane 3
    waddr = 6'd5; wdata = 32'h00000000; wren = 4'b1000;
    raddr[11:6] = 6'd5;
    #1;
    check("comb_bypass_a", 64'(rdata_a[63:32]), 64'h00BB33DD);
    tick();
    wren = '0;
    // Top address
    waddr = 6'd63; wdata = 32'hCAFEF00D; wren = 4'hF;
    tick();
    wren = '0;
    raddr[5:0] = 6'd63;
    #1;
    check("top_addr_a", 64'(rdata_a[31:0]), 64'hCAFEF00D);

    // 4. Same-edge write and read on both ports
    waddr = 6'd9; wdata = 32'h7; wren = 4'hF;
    tick();
    wdata = 32'h55; ren = 2'b11; raddr = {6'd9, 6'd9};
    tick();
    wren = '0; ren = '0;
    check("wfirst_b", rdata_b, {32'h55, 32'h55});
    check("wfirst_rvalid_b", 64'(rvalid_b), 64'b11);
    check("rfirst_c", rdata_c, {32'h7, 32'h7});
    check("rfirst_rvalid_c", 64'(rvalid_c), 64'b11);
    tick();
    check("rvalid_drop_b", 64'(rvalid_b), 64'b00);
    // Masked same-edge write: only lane 0 forwarded
    wdata = 32'hAABBCCDD; wren = 4'b0001; ren = 2'b11;
    tick();
    wren = '0; ren = '0;
    check("wfirst_mask_b", rdata_b, {32'h000000DD, 32'h000000DD});
    check("rfirst_mask_c", rdata_c, {32'h55, 32'h55});

    // 5. Port 1 holds data with ren low
    waddr = 6'd12; wdata = 32'hA; wren = 4'hF;
    tick();
    wren = '0; ren = 2'b10; raddr[11:6] = 6'd12;
    tick();
    check("hold_first_b", 64'(rdata_b[63:32]), 64'hA);
    check("hold_first_rvalid_b", 64'(rvalid_b[1]), 64'd1);
    ren = 2'b00; raddr[11:6] = 6'd9;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("hold_data_b[%0d]", k), 64'(rdata_b[63:32]), 64'hA);
      check($sformatf("hold_rvalid_b[%0d]", k), 64'(rvalid_b[1]), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
